// File: rtl/rtclock_adj.sv
// PTP-style real-time clock (sec/nsec) with fractional-ns rate trim, time load,
// step/slew offset correction and a 1PPS strobe on counted seconds rollover.
module rtclock_adj #(
    parameter int CLK_PERIOD_NS = 8,
    parameter int FRAC_BITS     = 16,
    parameter int SEC_W         = 48,
    parameter int ADJ_W         = 30,
    parameter int SLEW_NS       = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 i_set_valid,
    input  logic [SEC_W-1:0]     i_set_sec,
    input  logic [29:0]          i_set_nsec,
    input  logic                 i_adj_valid,
    input  logic                 i_adj_mode,
    input  logic [ADJ_W-1:0]     i_adj_nsec,
    output logic                 o_adj_ready,
    input  logic [FRAC_BITS:0]   i_trim,
    output logic [SEC_W-1:0]     o_sec,
    output logic [29:0]          o_nsec,
    output logic                 o_pps
);

    // 33 signed integer-ns bits hold nsec + increment + largest step without overflow.
    localparam int SUM_W = FRAC_BITS + 33;
    localparam logic signed [SUM_W-1:0] ONE_SEC = {33'd1_000_000_000, {FRAC_BITS{1'b0}}};
    localparam logic signed [SUM_W-1:0] INC     = {33'(CLK_PERIOD_NS), {FRAC_BITS{1'b0}}};

    typedef enum logic {IDLE, SLEW} state_t;

    state_t                state_reg, state_next;
    logic [ADJ_W-1:0]      remain_reg, remain_next;
    logic                  neg_reg, neg_next;
    logic [SEC_W-1:0]      sec_reg, sec_next;
    logic [29:0]           nsec_reg, nsec_next;
    logic [FRAC_BITS-1:0]  frac_reg, frac_next;
    logic                  pps_reg, pps_next;

    logic [ADJ_W-1:0]      adj_mag;
    logic [ADJ_W-1:0]      slew_step;
    logic [32:0]           step_ext;
    logic signed [32:0]    delta_ns;
    logic [SUM_W-1:0]      trim_ext;
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] norm;

    always_comb begin
        adj_mag   = i_adj_nsec[ADJ_W-1] ? (~i_adj_nsec + ADJ_W'(1)) : i_adj_nsec;
        slew_step = (remain_reg < ADJ_W'(SLEW_NS)) ? remain_reg : ADJ_W'(SLEW_NS);
        step_ext  = {{(33-ADJ_W){1'b0}}, slew_step};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg  <= IDLE;
            remain_reg <= '0;
            neg_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            remain_reg <= remain_next;
            neg_reg    <= neg_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        remain_next = remain_reg;
        neg_next    = neg_reg;
        if (i_set_valid) begin
            state_next  = IDLE;
            remain_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (i_adj_valid && i_adj_mode && (i_adj_nsec != '0)) begin
                        state_next  = SLEW;
                        remain_next = adj_mag;
                        neg_next    = i_adj_nsec[ADJ_W-1];
                    end
                end
                SLEW: begin
                    remain_next = remain_reg - slew_step;
                    if (remain_next == '0)
                        state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Offset contribution for this cycle; a step is taken only while idle.
    always_comb begin
        o_adj_ready = (state_reg == IDLE);
        delta_ns    = '0;
        case (state_reg)
            IDLE: begin
                if (i_adj_valid && !i_adj_mode)
                    delta_ns = {{(33-ADJ_W){i_adj_nsec[ADJ_W-1]}}, i_adj_nsec};
            end
            SLEW:    delta_ns = neg_reg ? -step_ext : step_ext;
            default: delta_ns = '0;
        endcase
    end

    always_comb begin
        trim_ext  = {{(SUM_W-FRAC_BITS-1){i_trim[FRAC_BITS]}}, i_trim};
        sum       = {3'b000, nsec_reg, frac_reg} + INC + trim_ext
                  + {delta_ns, {FRAC_BITS{1'b0}}};
        norm      = sum;
        sec_next  = sec_reg;
        pps_next  = 1'b0;
        if (sum[SUM_W-1]) begin
            norm     = sum + ONE_SEC;
            sec_next = sec_reg - SEC_W'(1);
        end else if (sum >= ONE_SEC) begin
            norm     = sum - ONE_SEC;
            sec_next = sec_reg + SEC_W'(1);
            pps_next = 1'b1;
        end
        nsec_next = 30'(norm >> FRAC_BITS);
        frac_next = FRAC_BITS'(norm);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sec_reg  <= '0;
            nsec_reg <= '0;
            frac_reg <= '0;
            pps_reg  <= 1'b0;
        end else if (i_set_valid) begin
            sec_reg  <= i_set_sec;
            nsec_reg <= i_set_nsec;
            frac_reg <= '0;
            pps_reg  <= 1'b0;
        end else begin
            sec_reg  <= sec_next;
            nsec_reg <= nsec_next;
            frac_reg <= frac_next;
            pps_reg  <= pps_next;
        end
    end

    assign o_sec  = sec_reg;
    assign o_nsec = nsec_reg;
    assign o_pps  = pps_reg;

endmodule
